cmp_search_initiator: RTL

Binary-search engine that drives the probe side of a magnitude-compare interface. It issues candidate values to an external comparator, which compares the probe (A) against a hidden target (B). It consumes the greater/less/equal responses and converges on the target in at most WIDTH+1 probes. It sits in front of comparator instances in the combinational library and is used for threshold discovery and for exercising comparators.

---
 rtl/cmp_search_initiator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cmp_search_initiator.sv
// Binary-search probe engine for a magnitude comparator: drives candidate values,
// consumes gt/lt/eq responses and converges on the hidden target.
module cmp_search_initiator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             rsp_valid,
  input  logic             rsp_gt,
  input  logic             rsp_lt,
  input  logic             rsp_eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       steps
);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       steps_q, steps_d;
  logic             probe_valid_q, probe_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] mid;
  logic             one_hot;
  logic             finish;

  // hi >= lo always holds in PROBE, so the difference never wraps
  assign mid     = lo_q + ((hi_q - lo_q) >> 1);
  assign one_hot = (rsp_gt ^ rsp_lt ^ rsp_eq) & ~(rsp_gt & rsp_lt & rsp_eq);

  // Outside PROBE the operand is parked at zero so idle/done outputs read clean
  assign probe       = (state_q == S_PROBE) ? mid : '0;
  assign probe_valid = probe_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign error       = error_q;
  assign result      = result_q;
  assign steps       = steps_q;

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    result_d      = result_q;
    steps_d       = steps_q;
    probe_valid_d = probe_valid_q;
    busy_d        = busy_q;
    done_d        = done_q;
    found_d       = found_q;
    error_d       = error_q;
    finish        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_PROBE;
          lo_d          = '0;
          hi_d          = '1;
          steps_d       = '0;
          result_d      = '0;
          done_d        = 1'b0;
          found_d       = 1'b0;
          error_d       = 1'b0;
          busy_d        = 1'b1;
          probe_valid_d = 1'b1;
        end
      end
      S_PROBE: begin
        if (rsp_valid) begin
          steps_d = (steps_q == 5'd31) ? steps_q : steps_q + 5'd1;
          if (!one_hot) begin
            finish   = 1'b1;
            error_d  = 1'b1;
            found_d  = 1'b0;
            result_d = '0;
          end else if (rsp_eq) begin
            finish   = 1'b1;
            found_d  = 1'b1;
            result_d = mid;
          end else if (rsp_gt) begin
            if (mid == lo_q) finish = 1'b1;
            else             hi_d   = mid - 1'b1;
          end else begin
            if (mid == hi_q) finish = 1'b1;
            else             lo_d   = mid + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d       = S_DONE;
      probe_valid_d = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lo_q          <= '0;
      hi_q          <= '1;
      result_q      <= '0;
      steps_q       <= '0;
      probe_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      result_q      <= result_d;
      steps_q       <= steps_d;
      probe_valid_q <= probe_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      error_q       <= error_d;
    end
  end

endmodule
